pkt_merger: RTL and testbench
=============================

// Module: pkt_merger
// PURPOSE
//  Return-direction counterpart of the packet router: merges NUM_CHANNELS incoming
//  packet streams (one per HSSL channel) into one outgoing stream. Fair round-robin
//  arbitration, registered output stage, full throughput (1 pkt/cycle).
// PARAMETERS
//  PACKET_BITS   72   packet width (key at [KEY_LSB +: 32], carried untouched)
//  NUM_CHANNELS  8    number of input channels (2..16)
//  DROP_WAIT     256  stall cycles before the held output packet is dropped (drop feature only)
// PORTS
//  clk               in   1                        clock
//  reset             in   1                        asynchronous, active-low reset
//  pkt_in_data_in    in   PACKET_BITS x NUM_CH     per-channel packet data
//  pkt_in_vld_in     in   1 x NUM_CH               per-channel valid
//  pkt_in_rdy_out    out  1 x NUM_CH               per-channel ready (only granted channel)
//  pkt_out_data_out  out  PACKET_BITS              merged packet data (registered)
//  pkt_out_vld_out   out  1                        merged packet valid (registered)
//  pkt_out_rdy_in    in   1                        downstream ready
//  mg_cnt_out        out  1                        1-cycle pulse per packet accepted into the output register
//  drp_cnt_out       out  1                        1-cycle pulse per dropped packet
// BEHAVIOUR
//  - Reset (async assert, sync deassert in clk domain): pkt_out_vld_out=0, pkt_out_data_out=0,
//    mg_cnt_out=0, drp_cnt_out=0, last_grant=NUM_CHANNELS-1 (ch 0 highest priority first), stall_cnt=0.
//  - load_en = !pkt_out_vld_out || pkt_out_rdy_in (output register empty or draining this cycle).
//  - Arbiter (comb.): grant = first ch with pkt_in_vld_in set, searching last_grant+1, +2, ...
//    cyclically (wrap NUM_CHANNELS-1 -> 0); no grant if no valid input.
//  - pkt_in_rdy_out[ch] = load_en && grant valid && grant==ch; all others 0. Ready may depend on
//    valid; valid never depends on ready.
//  - Transfer on clk edge when a granted input is valid and ready: data -> output register,
//    pkt_out_vld_out<=1, last_grant<=grant, mg_cnt_out<=1 (else 0). Latency input->output: 1 cycle.
//  - If load_en and no input valid: pkt_out_vld_out<=0 (when the held packet was taken).
//  - Output held stable (data and valid) while pkt_out_vld_out && !pkt_out_rdy_in.
//  - Simultaneous output take + new grant: back-to-back, no bubble.
//  - last_grant updates only on an actual transfer; idle cycles leave priority unchanged.
//  - Out-of-range channels never granted; pkt_in_data_in of non-granted channels ignored.
// CONFIGURATION
//  PKT_MERGER_DROP_EN defined:
//   - stall_cnt (clog2(DROP_WAIT+1) bits) increments each cycle pkt_out_vld_out && !pkt_out_rdy_in,
//     clears on any other cycle. On the cycle stall_cnt==DROP_WAIT-1 and still stalled:
//     pkt_out_vld_out<=0, drp_cnt_out<=1 for one cycle, stall_cnt<=0; no new load that cycle.
//   - Deliberate valid withdrawal (SpiNNaker-style drop) to prevent a dead channel blocking all inputs.
//  PKT_MERGER_DROP_EN undefined: no stall counter; drp_cnt_out tied 0; packet held indefinitely.
// TESTING
//  1. Only ch3 valid (data 72'hA5), out ready -> next cycle vld_out=1, data=72'hA5, mg_cnt_out pulse; rdy_out[3]=1 only.
//  2. All 8 ch valid continuously, out ready -> output order ch0,1,..,7,0,1 one per cycle, no bubbles.
//  3. ch2 and ch5 valid, last_grant=5 -> ch2 granted next, then ch5; then ch2 again (wrap check).
//  4. Output loaded, rdy_in low 5 cycles -> vld_out/data stable, all pkt_in_rdy_out=0; rdy_in high ->
//     held packet taken and next packet loaded same edge.
//  5. reset low mid-stream -> vld_out=0 immediately (async), after release ch0 wins first grant.
//  6. DROP_EN, DROP_WAIT=4, rdy_in held low -> vld_out falls after 4 stall cycles, drp_cnt_out 1-cycle
//     pulse, next valid input loaded following cycle; without DROP_EN -> held 100+ cycles, drp_cnt_out=0.

Source files
------------

// File: rtl/pkt_merger.sv
// Round-robin merge of NUM_CHANNELS packet streams into one registered output stream.
// Define PKT_MERGER_DROP_EN to drop an output packet stalled for DROP_WAIT cycles.
module pkt_merger #(
    parameter int PACKET_BITS  = 72,
    parameter int NUM_CHANNELS = 8,
    parameter int DROP_WAIT    = 256
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS*PACKET_BITS-1:0]  pkt_in_data_in,
    input  logic [NUM_CHANNELS-1:0]              pkt_in_vld_in,
    output logic [NUM_CHANNELS-1:0]              pkt_in_rdy_out,
    output logic [PACKET_BITS-1:0]               pkt_out_data_out,
    output logic                                 pkt_out_vld_out,
    input  logic                                 pkt_out_rdy_in,
    output logic                                 mg_cnt_out,
    output logic                                 drp_cnt_out
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [PACKET_BITS-1:0] data_q, data_d;
    logic                   vld_q, vld_d;
    logic [CH_W-1:0]        last_grant_q, last_grant_d;
    logic                   mg_q, mg_d;

    logic            load_en;
    logic            grant_vld;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] arb_idx;
    logic            transfer;

    assign load_en  = !vld_q || pkt_out_rdy_in;
    assign transfer = load_en && grant_vld;

    // Scan from furthest to nearest so the nearest valid channel after last_grant wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = last_grant_q;
        arb_idx   = '0;
        for (int i = NUM_CHANNELS; i >= 1; i--) begin
            arb_idx = CH_W'((int'(last_grant_q) + i) % NUM_CHANNELS);
            if (pkt_in_vld_in[arb_idx]) begin
                grant_vld = 1'b1;
                grant     = arb_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_rdy
            assign pkt_in_rdy_out[gi] = load_en && grant_vld && (grant == CH_W'(gi));
        end
    endgenerate

`ifdef PKT_MERGER_DROP_EN
    localparam int SC_W = $clog2(DROP_WAIT + 1);

    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            drp_q, drp_d;
    logic            stalled;

    assign stalled = vld_q && !pkt_out_rdy_in;
`endif

    always_comb begin
        data_d       = data_q;
        vld_d        = vld_q;
        last_grant_d = last_grant_q;
        mg_d         = 1'b0;
        if (transfer) begin
            data_d       = pkt_in_data_in[int'(grant)*PACKET_BITS +: PACKET_BITS];
            vld_d        = 1'b1;
            last_grant_d = grant;
            mg_d         = 1'b1;
        end else if (load_en) begin
            vld_d = 1'b0;
        end
`ifdef PKT_MERGER_DROP_EN
        drp_d       = 1'b0;
        stall_cnt_d = '0;
        // A stalled cycle never loads (load_en is low), so the drop only withdraws valid.
        if (stalled) begin
            if (stall_cnt_q == SC_W'(DROP_WAIT - 1)) begin
                vld_d = 1'b0;
                drp_d = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q       <= '0;
            vld_q        <= 1'b0;
            last_grant_q <= CH_W'(NUM_CHANNELS - 1);
            mg_q         <= 1'b0;
        end else begin
            data_q       <= data_d;
            vld_q        <= vld_d;
            last_grant_q <= last_grant_d;
            mg_q         <= mg_d;
        end
    end

`ifdef PKT_MERGER_DROP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            drp_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drp_q       <= drp_d;
        end
    end

    assign drp_cnt_out = drp_q;
`else
    assign drp_cnt_out = 1'b0;
`endif

    assign pkt_out_data_out = data_q;
    assign pkt_out_vld_out  = vld_q;
    assign mg_cnt_out       = mg_q;

endmodule

// File: tb/tb_pkt_merger.sv
// Directed bench for pkt_merger: arbitration order, back-pressure, async reset and drop.
module tb_pkt_merger;

    localparam int PB = 72;
    localparam int NC = 8;
`ifdef PKT_MERGER_DROP_EN
    localparam int DW        = 4;
    localparam int STALL_CYC = 3;
`else
    localparam int DW        = 256;
    localparam int STALL_CYC = 5;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [PB-1:0]    din [NC];
    logic [NC*PB-1:0] din_flat;
    logic [NC-1:0]    vld_in = '0;
    logic [NC-1:0]    rdy_out;
    logic [PB-1:0]    data_out;
    logic             vld_out;
    logic             rdy_in = 1'b0;
    logic             mg;
    logic             drp;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always_comb begin
        din_flat = '0;
        for (int i = 0; i < NC; i++) din_flat[i*PB +: PB] = din[i];
    end

    pkt_merger #(.PACKET_BITS(PB), .NUM_CHANNELS(NC), .DROP_WAIT(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .pkt_in_data_in   (din_flat),
        .pkt_in_vld_in    (vld_in),
        .pkt_in_rdy_out   (rdy_out),
        .pkt_out_data_out (data_out),
        .pkt_out_vld_out  (vld_out),
        .pkt_out_rdy_in   (rdy_in),
        .mg_cnt_out       (mg),
        .drp_cnt_out      (drp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        vld_in = '0;
        rdy_in = 1'b1;
        #12;
        vec++; if (vld_out !== 1'b0)  begin errs++; $display("FAIL reset_vld got %b exp 0", vld_out); end
        vec++; if (data_out !== '0)   begin errs++; $display("FAIL reset_data got %h exp 0", data_out); end
        vec++; if (mg !== 1'b0 || drp !== 1'b0) begin errs++; $display("FAIL reset_pulses got mg=%b drp=%b exp 0 0", mg, drp); end
        vec++; if (rdy_out !== '0)    begin errs++; $display("FAIL reset_rdy got %h exp 00", rdy_out); end
        $display("reset: vld=%b data=%h", vld_out, data_out);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single;
        din[3] = 72'hA5;
        vld_in = 8'h08;
        rdy_in = 1'b1;
        #1;
        vec++; if (rdy_out !== 8'h08) begin errs++; $display("FAIL single_rdy got %h exp 08", rdy_out); end
        tick;
        vld_in = '0;
        vec++; if (vld_out !== 1'b1 || data_out !== 72'hA5 || mg !== 1'b1)
            begin errs++; $display("FAIL single_out got vld=%b data=%h mg=%b exp 1 a5 1", vld_out, data_out, mg); end
        $display("single: ch3 -> data=%h mg=%b", data_out, mg);
        tick;
        vec++; if (vld_out !== 1'b0 || mg !== 1'b0)
            begin errs++; $display("FAIL single_idle got vld=%b mg=%b exp 0 0", vld_out, mg); end
    endtask

    task automatic test_all_valid;
        do_reset;
        for (int c = 0; c < NC; c++) din[c] = 72'h100 + PB'(c);
        vld_in = '1;
        rdy_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            vec++; if (rdy_out !== NC'(1 << (k % NC)))
                begin errs++; $display("FAIL all_rdy[%0d] got %h exp %h", k, rdy_out, NC'(1 << (k % NC))); end
            tick;
            vec++; if (vld_out !== 1'b1 || data_out !== 72'h100 + PB'(k % NC) || mg !== 1'b1)
                begin errs++; $display("FAIL all_out[%0d] got vld=%b data=%h mg=%b exp data %h", k, vld_out, data_out, mg, 72'h100 + PB'(k % NC)); end
            $display("all_valid: beat %0d data=%h", k, data_out);
        end
        vld_in = '0;
    endtask

    task automatic test_wrap;
        int seq [3] = '{2, 5, 2};
        do_reset;
        din[2] = 72'h22;
        din[5] = 72'h55;
        rdy_in = 1'b1;
        vld_in = 8'h20;
        tick;
        vec++; if (data_out !== 72'h55) begin errs++; $display("FAIL wrap_prime got %h exp 55", data_out); end
        vld_in = 8'h24;
        for (int k = 0; k < 3; k++) begin
            tick;
            vec++; if (vld_out !== 1'b1 || data_out !== ((seq[k] == 2) ? 72'h22 : 72'h55))
                begin errs++; $display("FAIL wrap[%0d] got vld=%b data=%h exp ch%0d", k, vld_out, data_out, seq[k]); end
            $display("wrap: beat %0d data=%h", k, data_out);
        end
        vld_in = '0;
    endtask

    task automatic test_stall;
        do_reset;
        din[0] = 72'hD0;
        din[1] = 72'hD1;
        vld_in = 8'h01;
        rdy_in = 1'b1;
        tick;
        vld_in = 8'h02;
        rdy_in = 1'b0;
        for (int k = 0; k < STALL_CYC; k++) begin
            #1;
            vec++; if (vld_out !== 1'b1 || data_out !== 72'hD0 || rdy_out !== '0)
                begin errs++; $display("FAIL stall[%0d] got vld=%b data=%h rdy=%h exp 1 d0 00", k, vld_out, data_out, rdy_out); end
            tick;
        end
        vec++; if (vld_out !== 1'b1 || data_out !== 72'hD0)
            begin errs++; $display("FAIL stall_end got vld=%b data=%h exp 1 d0", vld_out, data_out); end
        rdy_in = 1'b1;
        #1;
        vec++; if (rdy_out !== 8'h02) begin errs++; $display("FAIL stall_release_rdy got %h exp 02", rdy_out); end
        tick;
        vld_in = '0;
        vec++; if (vld_out !== 1'b1 || data_out !== 72'hD1 || mg !== 1'b1)
            begin errs++; $display("FAIL stall_b2b got vld=%b data=%h mg=%b exp 1 d1 1", vld_out, data_out, mg); end
        $display("stall: held %0d cycles, then data=%h", STALL_CYC, data_out);
    endtask

    task automatic test_async_reset;
        do_reset;
        for (int c = 0; c < NC; c++) din[c] = 72'h300 + PB'(c);
        vld_in = '1;
        rdy_in = 1'b1;
        tick;
        tick;
        vec++; if (data_out !== 72'h301) begin errs++; $display("FAIL areset_pre got %h exp 301", data_out); end
        reset = 1'b0;
        #1;
        vec++; if (vld_out !== 1'b0 || data_out !== '0)
            begin errs++; $display("FAIL areset_async got vld=%b data=%h exp 0 0", vld_out, data_out); end
        @(negedge clk);
        reset = 1'b1;
        tick;
        vec++; if (vld_out !== 1'b1 || data_out !== 72'h300)
            begin errs++; $display("FAIL areset_first got vld=%b data=%h exp 1 300", vld_out, data_out); end
        $display("async_reset: first after release data=%h", data_out);
        vld_in = '0;
    endtask

    task automatic test_drop;
        do_reset;
        din[4] = 72'hE4;
        din[6] = 72'hE6;
        vld_in = 8'h10;
        rdy_in = 1'b1;
        tick;
        vld_in = 8'h40;
        rdy_in = 1'b0;
`ifdef PKT_MERGER_DROP_EN
        for (int k = 0; k < DW - 1; k++) begin
            tick;
            vec++; if (vld_out !== 1'b1 || drp !== 1'b0 || data_out !== 72'hE4)
                begin errs++; $display("FAIL drop_hold[%0d] got vld=%b drp=%b data=%h exp 1 0 e4", k, vld_out, drp, data_out); end
        end
        tick;
        vec++; if (vld_out !== 1'b0 || drp !== 1'b1)
            begin errs++; $display("FAIL drop_pulse got vld=%b drp=%b exp 0 1", vld_out, drp); end
        vec++; if (rdy_out !== 8'h40) begin errs++; $display("FAIL drop_rdy got %h exp 40", rdy_out); end
        tick;
        vec++; if (vld_out !== 1'b1 || data_out !== 72'hE6 || drp !== 1'b0 || mg !== 1'b1)
            begin errs++; $display("FAIL drop_next got vld=%b data=%h drp=%b mg=%b exp 1 e6 0 1", vld_out, data_out, drp, mg); end
        $display("drop: dropped after %0d stall cycles, next data=%h", DW, data_out);
`else
        for (int k = 0; k < 120; k++) begin
            tick;
            vec++; if (vld_out !== 1'b1 || drp !== 1'b0 || data_out !== 72'hE4 || rdy_out !== '0)
                begin errs++; $display("FAIL nodrop_hold[%0d] got vld=%b drp=%b data=%h rdy=%h exp 1 0 e4 00", k, vld_out, drp, data_out, rdy_out); end
        end
        $display("nodrop: held 120 cycles, data=%h drp=%b", data_out, drp);
`endif
        vld_in = '0;
        rdy_in = 1'b1;
        tick;
    endtask

    initial begin
        for (int c = 0; c < NC; c++) din[c] = '0;
        test_reset;
        test_single;
        test_all_valid;
        test_wrap;
        test_stall;
        test_async_reset;
        test_drop;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
